// File: rtl/fpga_clk_activity_mon.sv
// fpga_clk_activity_mon: multi-channel clock activity monitor and heartbeat.
//
// Each monitored domain supplies a divided toggle. The toggle is synchronised
// into clk_i. Its edges are counted over a window of WIN_CYCLES clocks, and
// each channel reports alive/lost status, the last window's edge count and an
// LED blink that runs only while the channel is alive.
//
// Optional feature macro: FPGA_CLK_MON_STICKY_EN
//   When it is defined, the block adds clr_sticky_i and sticky_lost_o. These
//   give a per-channel sticky record of lost_o pulses.
//
// Ports:
//   clk_i          monitor clock
//   rst_i          synchronous active-high reset
//   en_i           enable; low holds every register at its reset value
//   toggle_i       [N_CH] asynchronous divided toggles, one per domain
//   alive_o        [N_CH] >= MIN_EDGES edges seen in last completed window
//   lost_o         [N_CH] 1-cycle pulse when alive_o falls
//   blink_o        [N_CH] LED square wave while alive, 0 otherwise
//   count_o        [N_CH*CNT_W] last window edge count, ch k at [k*CNT_W +: CNT_W]
//   count_valid_o  1-cycle pulse aligned with each count_o/alive_o update
//   clr_sticky_i   (sticky build) clears sticky_lost_o
//   sticky_lost_o  (sticky build) [N_CH] latched lost_o history

// Per-channel slice: synchroniser, edge counter, status and blink.
module fpga_clk_activity_ch #(
  parameter int CNT_W     = 16,
  parameter int MIN_EDGES = 2,
  parameter int BLINK_DIV = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,     // rst_i or !en_i: force reset values
  input  logic             term_i,    // terminal cycle of the window
  input  logic             toggle_i,
`ifdef FPGA_CLK_MON_STICKY_EN
  input  logic             clr_sticky_i,
  output logic             sticky_lost_o,
`endif
  output logic             alive_o,
  output logic             lost_o,
  output logic             blink_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int BL_W = (BLINK_DIV < 1) ? 1 : $clog2(BLINK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1, s2, s3;
  logic             edge_det;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             new_alive;
  logic [BL_W-1:0]  bl_cnt, bl_nxt;

  // The terminal cycle latches cnt_inc, so an edge that lands on that same
  // cycle still counts for the closing window.
  always_comb begin
    edge_det  = s2 ^ s3;
    cnt_inc   = (edge_det && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
    new_alive = (cnt_inc >= CNT_W'(MIN_EDGES));
    bl_nxt    = bl_cnt + BL_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      cnt     <= '0;
      count_o <= '0;
      alive_o <= 1'b0;
      lost_o  <= 1'b0;
      blink_o <= 1'b0;
      bl_cnt  <= '0;
    end else begin
      s1 <= toggle_i;
      s2 <= s1;
      s3 <= s2;
      if (term_i) begin
        count_o <= cnt_inc;
        cnt     <= '0;
        alive_o <= new_alive;
        lost_o  <= alive_o & ~new_alive;
        if (new_alive) begin
          if (bl_nxt == BL_W'(BLINK_DIV)) begin
            bl_cnt  <= '0;
            blink_o <= ~blink_o;
          end else begin
            bl_cnt  <= bl_nxt;
          end
        end else begin
          bl_cnt  <= '0;
          blink_o <= 1'b0;
        end
      end else begin
        cnt    <= cnt_inc;
        lost_o <= 1'b0;
      end
    end
  end

`ifdef FPGA_CLK_MON_STICKY_EN
  // Sets from the registered lost_o. A clear in the lost_o cycle therefore
  // loses to the set.
  always_ff @(posedge clk_i) begin
    if (clr_i) sticky_lost_o <= 1'b0;
    else       sticky_lost_o <= lost_o | (sticky_lost_o & ~clr_sticky_i);
  end
`endif
endmodule

module fpga_clk_activity_mon #(
  parameter int N_CH       = 2,
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = 16,
  parameter int MIN_EDGES  = 2,
  parameter int BLINK_DIV  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [N_CH-1:0]       toggle_i,
`ifdef FPGA_CLK_MON_STICKY_EN
  input  logic                  clr_sticky_i,
  output logic [N_CH-1:0]       sticky_lost_o,
`endif
  output logic [N_CH-1:0]       alive_o,
  output logic [N_CH-1:0]       lost_o,
  output logic [N_CH-1:0]       blink_o,
  output logic [N_CH*CNT_W-1:0] count_o,
  output logic                  count_valid_o
);
  localparam int WIN_W = $clog2(WIN_CYCLES);

  logic [WIN_W-1:0]            win_cnt;
  logic                        clr, term;
  logic [N_CH-1:0][CNT_W-1:0]  count_q;

  // rst_i takes priority over en_i. Both collapse to one clear.
  assign clr  = rst_i | ~en_i;
  assign term = (win_cnt == WIN_W'(WIN_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (clr) begin
      win_cnt       <= '0;
      count_valid_o <= 1'b0;
    end else begin
      win_cnt       <= term ? '0 : win_cnt + WIN_W'(1);
      count_valid_o <= term;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    fpga_clk_activity_ch #(
      .CNT_W     (CNT_W),
      .MIN_EDGES (MIN_EDGES),
      .BLINK_DIV (BLINK_DIV)
    ) u_ch (
      .clk_i         (clk_i),
      .clr_i         (clr),
      .term_i        (term),
      .toggle_i      (toggle_i[k]),
`ifdef FPGA_CLK_MON_STICKY_EN
      .clr_sticky_i  (clr_sticky_i),
      .sticky_lost_o (sticky_lost_o[k]),
`endif
      .alive_o       (alive_o[k]),
      .lost_o        (lost_o[k]),
      .blink_o       (blink_o[k]),
      .count_o       (count_q[k])
    );
  end

  assign count_o = count_q;
endmodule

// File: tb/tb_fpga_clk_activity_mon.sv
module tb_fpga_clk_activity_mon;
  logic        clk = 1'b0;
  logic        rst, en, clr_st;
  logic [1:0]  tog, tog2;
  logic [1:0]  alive, lost, blink, alive2, lost2, blink2;
  logic [31:0] count;
  logic [5:0]  count2;
  logic        valid, valid2;
`ifdef FPGA_CLK_MON_STICKY_EN
  logic [1:0]  sticky, sticky2;
`endif

  int checks = 0, errors = 0;
  int n = 0;
  int lost0 = 0, lost1 = 0, vcnt = 0, vsnap;
  int lo[2], hi[2], per[2];

  always #5 clk = ~clk;

  fpga_clk_activity_mon #(.N_CH(2), .WIN_CYCLES(16), .CNT_W(16), .MIN_EDGES(2), .BLINK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .toggle_i(tog),
`ifdef FPGA_CLK_MON_STICKY_EN
    .clr_sticky_i(clr_st), .sticky_lost_o(sticky),
`endif
    .alive_o(alive), .lost_o(lost), .blink_o(blink), .count_o(count), .count_valid_o(valid));

  // Narrow counters for the saturation check.
  fpga_clk_activity_mon #(.N_CH(2), .WIN_CYCLES(16), .CNT_W(3), .MIN_EDGES(2), .BLINK_DIV(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .toggle_i(tog2),
`ifdef FPGA_CLK_MON_STICKY_EN
    .clr_sticky_i(clr_st), .sticky_lost_o(sticky2),
`endif
    .alive_o(alive2), .lost_o(lost2), .blink_o(blink2), .count_o(count2), .count_valid_o(valid2));

  always @(negedge clk) begin
    if (lost[0]) lost0++;
    if (lost[1]) lost1++;
    if (valid)   vcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got %0h exp %0h", tag, n, got, exp);
    end
  endtask

  // Each channel follows a flip program: every per[k] steps between lo and hi.
  task automatic apply_flips();
    for (int k = 0; k < 2; k++)
      if (per[k] != 0 && n >= lo[k] && n <= hi[k] && ((n - lo[k]) % per[k]) == 0)
        tog[k] = ~tog[k];
    tog2[1] = ~tog2[1];
  endtask

  task automatic tick();
    @(posedge clk); #1;
    n++;
    apply_flips();
  endtask

  task automatic ticks_to(input int t);
    while (n < t) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tog = '0; tog2 = '0; clr_st = 1'b0;
    per = '{0, 0}; lo = '{0, 0}; hi = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alive", alive, 0);
    chk("rst_lost",  lost, 0);
    chk("rst_blink", blink, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);

    // Static toggles first, then ch0 flips every 2 cycles starting at n=16.
    lo[0] = 16; hi[0] = 108; per[0] = 2;
    rst = 1'b0; en = 1'b1; n = 0; apply_flips();
    ticks_to(15); chk("a_valid15", valid, 0);
    ticks_to(16);
    chk("a_valid16", valid, 1);
    chk("a_count16", count, 0);
    chk("a_alive16", alive, 0);
    chk("a_blink16", blink, 0);
    chk("sat_16", count2, {3'd7, 3'd0});
    tick(); chk("a_valid17", valid, 0);
    ticks_to(32);
    chk("b_count32", count, 32'd7);
    chk("b_alive32", alive, 2'b01);
    chk("b_blink32", blink, 2'b00);
    chk("sat_32", count2, {3'd7, 3'd0});
    ticks_to(48);
    chk("b_count48", count, 32'd8);
    chk("b_blink48", blink, 2'b01);
    ticks_to(64); chk("b_blink64", blink, 2'b01);
    ticks_to(80); chk("b_blink80", blink, 2'b00);
    ticks_to(112);
    chk("b_count112", count, 32'd8);
    chk("b_blink112", blink, 2'b01);
    chk("b_lost_none", lost0, 0);

    // ch0 went quiet after n=111. Window 8 is fully quiet.
    lo[0] = 130; hi[0] = 130; per[0] = 1;
    ticks_to(128);
    chk("c_count128", count, 0);
    chk("c_alive128", alive, 2'b00);
    chk("c_lost128",  lost, 2'b01);
    chk("c_blink128", blink, 2'b00);
    tick(); chk("c_lost129", lost, 2'b00);

    // One edge in a window stays below threshold. Two edges reach it.
    ticks_to(144);
    chk("d_count1", count, 32'd1);
    chk("d_alive1", alive, 2'b00);
    chk("d_valid1", valid, 1);
    lo[0] = 146; hi[0] = 150; per[0] = 4;
    ticks_to(160);
    chk("d_count2", count, 32'd2);
    chk("d_alive2", alive, 2'b01);

    // Reset at win_cnt=9.
    ticks_to(169); chk("e_alive169", alive, 2'b01);
    rst = 1'b1; vsnap = vcnt;
    tick();
    chk("e_rst_alive", alive, 0);
    chk("e_rst_count", count, 0);
    chk("e_rst_valid", valid, 0);
    chk("e_rst_blink", blink, 0);
    chk("e_rst_lost",  lost, 0);
    ticks_to(190);
    chk("e_no_valid", vcnt, vsnap);
    chk("e_lost0_total", lost0, 1);

    // ch1 alive for two windows, then lost. Also exercises sticky set and clear.
    per[0] = 0; lo[1] = 0; hi[1] = 20; per[1] = 2;
    rst = 1'b0; en = 1'b1; n = 0; apply_flips();
    ticks_to(16);
    chk("f_count16", count, {16'd7, 16'd0});
    chk("f_alive16", alive, 2'b10);
    ticks_to(32);
    chk("f_count32", count, {16'd4, 16'd0});
    chk("f_blink32", blink, 2'b10);
    ticks_to(48);
    chk("f_alive48", alive, 2'b00);
    chk("f_lost48",  lost, 2'b10);
    chk("f_blink48", blink, 2'b00);
    tick();
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_set49", sticky, 2'b10);
`endif
    ticks_to(80);
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_hold80", sticky, 2'b10);
`endif
    clr_st = 1'b1; tick(); clr_st = 1'b0;
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_clr81", sticky, 2'b00);
`endif
    lo[1] = 82; hi[1] = 100; per[1] = 2;
    ticks_to(96);  chk("f_count96", count, {16'd6, 16'd0});
    ticks_to(112); chk("f_alive112", alive, 2'b10);
    ticks_to(128);
    chk("f_lost128", lost, 2'b10);
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_pre128", sticky, 2'b00);
`endif
    clr_st = 1'b1; tick(); clr_st = 1'b0;
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_setclr129", sticky, 2'b10);
`endif
    tick();
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("s_hold130", sticky, 2'b10);
`endif
    chk("f_lost1_total", lost1, 2);

    // en_i low clears everything. Re-enable restarts window 0.
    per[1] = 0; tog[1] = 1'b0;
    en = 1'b0; tick();
    chk("g_en_alive", alive, 0);
    chk("g_en_count", count, 0);
    chk("g_en_valid", valid, 0);
`ifdef FPGA_CLK_MON_STICKY_EN
    chk("g_en_sticky", sticky, 2'b00);
`endif
    lo[0] = 0; hi[0] = 30; per[0] = 2;
    en = 1'b1; n = 0; apply_flips();
    ticks_to(16);
    chk("g_count16", count, 32'd7);
    chk("g_alive16", alive, 2'b01);
    ticks_to(20);
    en = 1'b0; tick();
    chk("g_off_alive", alive, 0);
    chk("g_off_count", count, 0);
    chk("g_off_blink", blink, 0);
    chk("g_off_valid", valid, 0);
    repeat (3) tick();
    chk("g_lost0_total", lost0, 1);
    chk("g_lost1_total", lost1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
